// File: rtl/regfile_fwd_multi_pkg.sv
// Shared constants and types for the forwarding register file: default widths,
// the hard-wired zero register address, FSM encodings and control polarities.
package regfile_fwd_multi_pkg;

   localparam int RegBusW  = 16;
   localparam int RegAddrW = 3;
   localparam int RegZero  = 0;

   localparam logic RstEnable   = 1'b1;
   localparam logic WriteEnable = 1'b1;
   localparam logic ReadEnable  = 1'b1;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

endpackage

// File: rtl/regfile_fwd_multi_sel.sv
// One read port: prioritised forwarding mux (youngest source first, then the
// same-cycle WB write, then the array) plus the load-use hazard flag.
module regfile_fwd_sel
   import regfile_fwd_multi_pkg::*;
#(
   parameter int DATA_W   = RegBusW,
   parameter int ADDR_W   = RegAddrW,
   parameter int NUM_FWD  = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                        active,
   input  logic                        re,
   input  logic [ADDR_W-1:0]           raddr,
   input  logic [DATA_W-1:0]           reg_data,
   input  logic                        we,
   input  logic [ADDR_W-1:0]           waddr,
   input  logic [DATA_W-1:0]           wdata,
   input  logic [NUM_FWD-1:0]          fwd_we,
   input  logic [NUM_FWD*ADDR_W-1:0]   fwd_addr,
   input  logic [NUM_FWD*DATA_W-1:0]   fwd_data,
   input  logic [NUM_FWD-1:0]          fwd_pend,
   output logic [DATA_W-1:0]           rdata,
   output logic                        hazard
);

   logic              hit;
   logic              hit_pend;
   logic [DATA_W-1:0] hit_data;

   // Walk oldest to youngest so the lowest matching index is the one left standing.
   always_comb begin
      hit      = 1'b0;
      hit_pend = 1'b0;
      hit_data = '0;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
         if (fwd_we[k] == WriteEnable && fwd_addr[k*ADDR_W +: ADDR_W] == raddr) begin
            hit      = 1'b1;
            hit_pend = fwd_pend[k];
            hit_data = fwd_data[k*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      rdata  = '0;
      hazard = 1'b0;
      if (active && re == ReadEnable) begin
         if (ZERO_REG == 1 && raddr == ADDR_W'(RegZero)) begin
            rdata = '0;
         end else if (hit) begin
            if (hit_pend) begin
               hazard = 1'b1;
            end else begin
               rdata = hit_data;
            end
         end else if (we == WriteEnable && waddr == raddr) begin
            rdata = wdata;
         end else begin
            rdata = reg_data;
         end
      end
   end

endmodule

// File: rtl/regfile_fwd_multi.sv
// ID-stage register file with NUM_RD forwarding read ports, load-use stall
// detection and a post-reset clearing sweep that gates the pipeline via ready_o.
module regfile_fwd_multi
   import regfile_fwd_multi_pkg::*;
#(
   parameter int DATA_W   = RegBusW,
   parameter int ADDR_W   = RegAddrW,
   parameter int NUM_RD   = 2,
   parameter int NUM_FWD  = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        we_i,
   input  logic [ADDR_W-1:0]           waddr_i,
   input  logic [DATA_W-1:0]           wdata_i,
   input  logic [NUM_FWD-1:0]          fwd_we_i,
   input  logic [NUM_FWD*ADDR_W-1:0]   fwd_addr_i,
   input  logic [NUM_FWD*DATA_W-1:0]   fwd_data_i,
   input  logic [NUM_FWD-1:0]          fwd_pend_i,
   input  logic [NUM_RD-1:0]           re_i,
   input  logic [NUM_RD*ADDR_W-1:0]    raddr_i,
   output logic [NUM_RD*DATA_W-1:0]    rdata_o,
   output logic                        stall_o,
   output logic                        ready_o
);

   state_t              state;
   state_t              next_state;
   logic [ADDR_W-1:0]   clr_idx;
   logic [DATA_W-1:0]   regs [2**ADDR_W];
   logic [NUM_RD-1:0]   hazard;

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state   <= CLEAR;
         clr_idx <= '0;
      end else begin
         state <= next_state;
         if (state == CLEAR) begin
            clr_idx <= clr_idx + ADDR_W'(1);
         end
      end
   end

   always_comb begin
      next_state = state;
      if (state == CLEAR && clr_idx == {ADDR_W{1'b1}}) begin
         next_state = READY;
      end
   end

   // The array has no reset of its own; the sweep zeroes it one entry per cycle.
   always_ff @(posedge clk) begin
      if (rst != RstEnable) begin
         if (state == CLEAR) begin
            regs[clr_idx] <= '0;
         end else if (we_i == WriteEnable &&
                      !(ZERO_REG == 1 && waddr_i == ADDR_W'(RegZero))) begin
            regs[waddr_i] <= wdata_i;
         end
      end
   end

   assign ready_o = (state == READY) && (rst != RstEnable);

   for (genvar p = 0; p < NUM_RD; p++) begin : g_port
      logic [ADDR_W-1:0] port_addr;
      assign port_addr = raddr_i[p*ADDR_W +: ADDR_W];

      regfile_fwd_sel #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .NUM_FWD  (NUM_FWD),
         .ZERO_REG (ZERO_REG)
      ) u_sel (
         .active   (ready_o),
         .re       (re_i[p]),
         .raddr    (port_addr),
         .reg_data (regs[port_addr]),
         .we       (we_i),
         .waddr    (waddr_i),
         .wdata    (wdata_i),
         .fwd_we   (fwd_we_i),
         .fwd_addr (fwd_addr_i),
         .fwd_data (fwd_data_i),
         .fwd_pend (fwd_pend_i),
         .rdata    (rdata_o[p*DATA_W +: DATA_W]),
         .hazard   (hazard[p])
      );
   end

   assign stall_o = |hazard;

endmodule
